// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MAX_W         = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Caller sign-extends to MAX_W; the magnitude of the most negative value
   // fits once truncated back to the operand width as an unsigned number.
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v);
      return v[MAX_W-1] ? (~v + MAX_W'(1)) : v;
   endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-and-add iteration: conditional accumulate, then shift operands.
module mult_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [2*WIDTH-1:0] mcand_next,
   output logic [WIDTH-1:0]   mplier_next
);

   assign acc_next    = mplier[0] ? (acc + mcand) : acc;
   assign mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
   assign mplier_next = {1'b0, mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_multiplier.sv
// Iterative signed multiplier: magnitudes are multiplied by shift-and-add, sign fixed at the end.
// Optional macro MULT_EARLY_EXIT_EN: leave BUSY once the remaining multiplier bits are all zero.
//
//  state | meaning
//  IDLE  | ready for operands
//  BUSY  | one shift-and-add iteration per cycle
//  FIX   | apply sign, register result and overflow
//  DONE  | result valid, waiting for out_ready
module seq_shift_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             busy
);

   state_t             state, state_next;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic [WIDTH-1:0]   result_q;
   logic               overflow_q;

   logic [2*WIDTH-1:0] acc_next, mcand_next;
   logic [WIDTH-1:0]   mplier_next;
   logic [MAX_W-1:0]   a_ext, b_ext;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     product_top;
   logic               last_iter, busy_exit;

   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc         (acc),
      .mcand       (mcand),
      .mplier      (mplier),
      .acc_next    (acc_next),
      .mcand_next  (mcand_next),
      .mplier_next (mplier_next)
   );

   // WIDTH must not exceed MAX_W for the sign-extend/abs path below.
   assign a_ext = MAX_W'($signed(operand_a));
   assign b_ext = MAX_W'($signed(operand_b));

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
   assign busy_exit = last_iter || (mplier_next == '0);
`else
   assign busy_exit = last_iter;
`endif

   assign product     = neg ? (-acc) : acc;
   assign product_top = product[2*WIDTH-1:WIDTH-1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = BUSY;
         BUSY:    if (busy_exit) state_next = FIX;
         FIX:                    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         cnt        <= '0;
         neg        <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, WIDTH'(abs_val(a_ext))};
                  mplier <= WIDTH'(abs_val(b_ext));
                  neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand_next;
               mplier <= mplier_next;
               cnt    <= cnt + CNT_W'(1);
            end
            FIX: begin
               result_q   <= product[WIDTH-1:0];
               overflow_q <= !((&product_top) || (~|product_top));
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = result_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Self-checking bench for seq_shift_multiplier against a 64-bit arithmetic reference model.
module tb_seq_shift_multiplier;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         in_ready, out_valid, overflow, busy;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   seq_shift_multiplier #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic longint model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = model_prod(a, b);
      return p[W-1:0];
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p, lim;
      p   = model_prod(a, b);
      lim = longint'(1) <<< (W - 1);
      return (p >= lim) || (p < -lim);
   endfunction

   // Edges from the accept edge (counted as 1) to the edge after which out_valid is high.
   function automatic int model_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
      longint m;
      int n;
      m = $signed(b);
      if (m < 0) m = -m;
      n = 0;
      while (m != 0) begin
         n++;
         m = m >> 1;
      end
      if (n < 1) n = 1;
      return n + 2;
`else
      return W + 2;
`endif
   endfunction

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] special [5];
      special = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF};
      if ($urandom_range(0, 7) == 0) return special[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) return W'($signed($urandom_range(0, 600)) - 300);
      return W'($urandom);
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] res,
                         output logic ovf, output bit tmo);
      int n;
      tmo = 1'b0;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) tmo = 1'b1;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (!out_valid) tmo = 1'b1;
      res = result;
      ovf = overflow;
   endtask

   task automatic release_result();
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h expected 0", result); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [12];
      logic [W-1:0] tb [12];
      int lat;
      logic [W-1:0] res;
      logic ovf;
      bit tmo;
      ta = '{32'd6, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000,
             32'h7FFF_FFFF, 32'd0, 32'd12345, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
      tb = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF,
             32'd2, 32'd0, 32'd1, 32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 12; i++) begin
         run_op(ta[i], tb[i], lat, res, ovf, tmo);
         checks++; if (tmo) begin errors++; $display("FAIL basic_timeout[%0d] got timeout expected out_valid", i); end
         checks++; if (res !== model_res(ta[i], tb[i])) begin errors++; $display("FAIL basic_result[%0d] %h*%h got %h expected %h", i, ta[i], tb[i], res, model_res(ta[i], tb[i])); end
         checks++; if (ovf !== model_ovf(ta[i], tb[i])) begin errors++; $display("FAIL basic_overflow[%0d] %h*%h got %b expected %b", i, ta[i], tb[i], ovf, model_ovf(ta[i], tb[i])); end
         checks++; if (lat != model_lat(tb[i])) begin errors++; $display("FAIL basic_latency[%0d] got %0d expected %0d", i, lat, model_lat(tb[i])); end
         release_result();
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [W-1:0] res;
      logic ovf;
      bit tmo;
      run_op(32'd9, 32'd9, lat, res, ovf, tmo);
      release_result();
      checks++; if (result !== 32'd81) begin errors++; $display("FAIL pre_reset_result got %h expected %h", result, 32'd81); end
      @(negedge clock);
      operand_a = 32'h0000_1234;
      operand_b = 32'h7000_0003;
      in_valid  = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy); end
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b expected 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL mid_reset_result got %h expected 0", result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
      @(negedge clock);
      reset_n = 1'b1;
      run_op(32'd3, 32'd5, lat, res, ovf, tmo);
      checks++; if (tmo || res !== 32'd15 || ovf !== 1'b0) begin errors++; $display("FAIL after_reset_op got res=%h ovf=%b tmo=%b expected %h 0 0", res, ovf, tmo, 32'd15); end
      release_result();
   endtask

   task automatic test_handshake();
      int lat, n;
      logic [W-1:0] res, exp;
      logic ovf;
      bit tmo;
      run_op(32'h0000_1234, 32'hFFFF_FF00, lat, res, ovf, tmo);
      exp = model_res(32'h0000_1234, 32'hFFFF_FF00);
      checks++; if (tmo || lat != model_lat(32'hFFFF_FF00)) begin errors++; $display("FAIL hs_latency got %0d tmo=%b expected %0d", lat, tmo, model_lat(32'hFFFF_FF00)); end
      checks++; if (res !== exp) begin errors++; $display("FAIL hs_result got %h expected %h", res, exp); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         in_valid  = 1'b1;
         operand_a = W'($urandom);
         operand_b = W'($urandom);
         out_ready = 1'b0;
         @(posedge clock);
         #1;
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin errors++; $display("FAIL hs_hold[%0d] got valid=%b ready=%b res=%h expected 1 0 %h", k, out_valid, in_ready, result, exp); end
      end
      @(negedge clock);
      operand_a = 32'd77;
      operand_b = 32'd3;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hs_release got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
      @(negedge clock);
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_next_accept got busy=%b expected 1", busy); end
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++; if (!out_valid || result !== 32'd231) begin errors++; $display("FAIL hs_next_result got valid=%b res=%h expected 1 %h", out_valid, result, 32'd231); end
      release_result();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cur_a, cur_b, prev_b;
      int acc_cyc, prev_cyc, n;
      @(negedge clock);
      cur_a = pick_operand();
      cur_b = pick_operand();
      prev_b = cur_b;
      prev_cyc = 0;
      operand_a = cur_a;
      operand_b = cur_b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clock);
         #1;
         acc_cyc = cyc;
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got busy=%b expected 1", i, busy); end
         if (i > 0) begin
            checks++; if (acc_cyc - prev_cyc != model_lat(prev_b) + 1) begin errors++; $display("FAIL b2b_period[%0d] got %0d expected %0d", i, acc_cyc - prev_cyc, model_lat(prev_b) + 1); end
         end
         n = 0;
         while (!out_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
         end
         checks++;
         if (!out_valid || result !== model_res(cur_a, cur_b) || overflow !== model_ovf(cur_a, cur_b)) begin
            errors++;
            $display("FAIL b2b_result[%0d] %h*%h got valid=%b res=%h ovf=%b expected %h %b", i, cur_a, cur_b, out_valid, result, overflow, model_res(cur_a, cur_b), model_ovf(cur_a, cur_b));
         end
         prev_cyc = acc_cyc;
         prev_b   = cur_b;
         @(negedge clock);
         cur_a = pick_operand();
         cur_b = pick_operand();
         operand_a = cur_a;
         operand_b = cur_b;
         @(posedge clock);
      end
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (100) @(posedge clock);
      #1;
      if (out_valid) release_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_handshake();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
